// File: rtl/mux3_1_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux3_1_rr_sched_if
//   Bundles the requester side and the output side of the 3:1 round-robin
//   scheduler into a single interface.
//
//   Signals
//     in_valid  [2:0]        request per source (bit i = source i)
//     in_data0..2 [WIDTH-1:0] source payloads
//     in_ready  [2:0]        one-hot (or zero) accept strobe per source
//     sel       [1:0]        mux select of the current grant (never 2'b11)
//     out_valid              output buffer holds valid data
//     out_data  [WIDTH-1:0]  registered mux output
//     out_src   [1:0]        source index of out_data
//     out_ready              downstream accept
//
//   Modports
//     slave  : the scheduler itself
//     master : the environment (requesters and downstream sink)
// -----------------------------------------------------------------------------
interface mux3_1_rr_sched_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       in_valid;
   logic [WIDTH-1:0] in_data0;
   logic [WIDTH-1:0] in_data1;
   logic [WIDTH-1:0] in_data2;
   logic [2:0]       in_ready;
   logic [1:0]       sel;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_src;
   logic             out_ready;

   modport slave (
      input  in_valid,
      input  in_data0,
      input  in_data1,
      input  in_data2,
      input  out_ready,
      output in_ready,
      output sel,
      output out_valid,
      output out_data,
      output out_src
   );

   modport master (
      output in_valid,
      output in_data0,
      output in_data1,
      output in_data2,
      output out_ready,
      input  in_ready,
      input  sel,
      input  out_valid,
      input  out_data,
      input  out_src
   );
endinterface

// File: rtl/mux3_1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux3_1_rr_sched
//   Round-robin scheduler sharing one 3:1 datapath mux between three
//   valid/ready requesters. The selected payload is captured into a one-entry
//   registered output buffer. With BURST > 1 a granted source may keep the
//   mux for up to BURST consecutive transfers before the grant rotates.
//
//   Parameters
//     WIDTH : payload width
//     BURST : max consecutive transfers per source (1..15, 1 = pure RR)
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : scheduler side (slave modport) of mux3_1_rr_sched_if
// -----------------------------------------------------------------------------
module mux3_1_rr_sched #(
   parameter int WIDTH = 8,
   parameter int BURST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux3_1_rr_sched_if.slave     bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [3:0] BURST_LIM = 4'(BURST - 1);

   state_t           state;
   state_t           state_nxt;

   // Arbitration state
   logic [1:0]       last;
   logic [3:0]       burst_cnt;
   logic             held;       // last holds a real grant (not the reset seed)
   logic [1:0]       sel_q;

   // Output buffer
   logic [WIDTH-1:0] data_p1;
   logic [1:0]       src_p1;
   logic             vld_p1;

   // Combinational arbitration
   logic             any_valid;
   logic             load_en;
   logic             xfer;
   logic [1:0]       cand1;
   logic [1:0]       cand2;
   logic [1:0]       winner;
   logic [WIDTH-1:0] mux_out;
   logic [2:0]       ready_c;
   logic [1:0]       sel_c;

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Burst counter saturates at BURST-1 rather than wrapping.
   function automatic logic [3:0] burst_inc(input logic [3:0] c);
      return (c >= BURST_LIM) ? BURST_LIM : c + 4'd1;
   endfunction

   initial begin : param_check
      if (BURST < 1 || BURST > 15) begin
         $fatal(1, "BURST out of range");
      end
   end

   assign any_valid = |bus.in_valid;

   // Winner: burst owner first (only while it still has budget), otherwise
   // search last+1, last+2, last. The reset seed last=2 is not a real owner,
   // so the held flag keeps it from claiming the burst exception.
   always_comb begin
      cand1  = next_src(last);
      cand2  = next_src(cand1);
      winner = last;
      if (held && (burst_cnt < BURST_LIM) && bus.in_valid[last]) begin
         winner = last;
      end else if (bus.in_valid[cand1]) begin
         winner = cand1;
      end else if (bus.in_valid[cand2]) begin
         winner = cand2;
      end else begin
         winner = last;
      end
   end

   always_comb begin
      case (winner)
         2'd0:    mux_out = bus.in_data0;
         2'd1:    mux_out = bus.in_data1;
         default: mux_out = bus.in_data2;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (xfer) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            // In FULL, load_en means the buffer is being popped.
            if (load_en && !xfer) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // FSM: outputs. in_ready and sel are forced low during reset because
   // load_en alone would be true there (buffer empty).
   always_comb begin
      vld_p1  = (state == FULL);
      load_en = !vld_p1 || bus.out_ready;
      ready_c = 3'b000;
      sel_c   = 2'b00;
      if (rst_n) begin
         if (load_en && any_valid) begin
            ready_c[winner] = 1'b1;
         end
         sel_c = any_valid ? winner : sel_q;
      end
   end

   assign xfer = |(bus.in_valid & ready_c);

   // Arbitration state update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= 2'd2;
         burst_cnt <= 4'd0;
         held      <= 1'b0;
         sel_q     <= 2'b00;
      end else begin
         if (any_valid) begin
            sel_q <= winner;
         end
         if (xfer) begin
            last      <= winner;
            held      <= 1'b1;
            burst_cnt <= (held && (winner == last)) ? burst_inc(burst_cnt) : 4'd0;
         end
      end
   end

   // ---- stage p1: output buffer ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1 <= '0;
         src_p1  <= 2'b00;
      end else if (xfer) begin
         data_p1 <= mux_out;
         src_p1  <= winner;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.sel       = sel_c;
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_src   = src_p1;

endmodule

// File: tb/tb_mux3_1_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux3_1_rr_sched
//   Directed bench for mux3_1_rr_sched. Instance a uses BURST=1 (pure
//   round-robin), instance b uses BURST=3. Inputs change 1 time unit after
//   the rising edge; outputs are observed a further time unit later.
// -----------------------------------------------------------------------------
module tb_mux3_1_rr_sched;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   mux3_1_rr_sched_if #(.WIDTH(8)) a ();
   mux3_1_rr_sched_if #(.WIDTH(8)) b ();

   mux3_1_rr_sched #(.WIDTH(8), .BURST(1)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a)
   );

   mux3_1_rr_sched #(.WIDTH(8), .BURST(3)) u_bu (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rot_d [3];
   logic [7:0] bu_d  [3];
   int         bu_src [11];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rot_d  = '{8'hA0, 8'hB1, 8'hC2};
      bu_d   = '{8'h10, 8'h21, 8'h32};
      bu_src = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0};

      rst_n       = 1'b0;
      a.in_valid  = 3'b111;
      a.in_data0  = 8'hA0;
      a.in_data1  = 8'hB1;
      a.in_data2  = 8'hC2;
      a.out_ready = 1'b1;
      b.in_valid  = 3'b000;
      b.in_data0  = 8'h10;
      b.in_data1  = 8'h21;
      b.in_data2  = 8'h32;
      b.out_ready = 1'b1;

      // Reset held for 3 cycles with all sources requesting
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", a.out_valid, 1'b0);
      chk("rst_in_ready",  a.in_ready,  3'b000);
      chk("rst_sel",       a.sel,       2'b00);
      chk("rst_out_data",  a.out_data,  8'h00);
      chk("rst_out_src",   a.out_src,   2'b00);

      rst_n = 1'b1;
      #1;
      chk("first_in_ready", a.in_ready, 3'b001);
      chk("first_sel",      a.sel,      2'b00);

      // Full contention: A0,B1,C2,A0
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rot_valid",    a.out_valid, 1'b1);
         chk("rot_data",     a.out_data,  rot_d[i % 3]);
         chk("rot_src",      a.out_src,   32'(i % 3));
         chk("rot_in_ready", a.in_ready,  32'(1) << ((i + 1) % 3));
      end

      // Sparse: last=0, source 1 silent -> grant 2, then 0
      a.in_valid = 3'b101;
      #1;
      chk("skip_in_ready", a.in_ready, 3'b100);
      chk("skip_sel",      a.sel,      2'b10);
      step();
      chk("skip_data", a.out_data, 8'hC2);
      chk("skip_src",  a.out_src,  2'd2);
      a.in_valid = 3'b001;
      #1;
      chk("wrap_in_ready", a.in_ready, 3'b001);
      chk("wrap_sel",      a.sel,      2'b00);
      step();
      chk("wrap_data", a.out_data, 8'hA0);
      chk("wrap_src",  a.out_src,  2'd0);

      // No requests: sel holds, buffer drains, payload holds
      a.in_valid = 3'b000;
      #1;
      chk("idle_in_ready", a.in_ready, 3'b000);
      chk("idle_sel",      a.sel,      2'b00);
      step();
      chk("idle_out_valid", a.out_valid, 1'b0);
      chk("idle_out_data",  a.out_data,  8'hA0);
      chk("idle_out_src",   a.out_src,   2'd0);

      // Backpressure: load 0x55 from source 0, then stall 4 cycles
      a.in_data0 = 8'h55;
      a.in_valid = 3'b001;
      step();
      chk("bp_load_data",  a.out_data,  8'h55);
      chk("bp_load_valid", a.out_valid, 1'b1);
      a.in_data0  = 8'hA0;
      a.in_valid  = 3'b111;
      a.out_ready = 1'b0;
      #1;
      chk("bp_in_ready", a.in_ready, 3'b000);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_stall_data",  a.out_data,  8'h55);
         chk("bp_stall_valid", a.out_valid, 1'b1);
         chk("bp_stall_src",   a.out_src,   2'd0);
         chk("bp_stall_ready", a.in_ready,  3'b000);
      end
      a.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", a.in_ready, 3'b010);
      chk("bp_release_sel",   a.sel,      2'b01);
      step();
      chk("bp_next_data", a.out_data, 8'hB1);
      chk("bp_next_src",  a.out_src,  2'd1);

      // Async reset between edges while the buffer is full
      step();
      chk("pre_rst_valid", a.out_valid, 1'b1);
      chk("pre_rst_data",  a.out_data,  8'hC2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", a.out_valid, 1'b0);
      chk("arst_out_data",  a.out_data,  8'h00);
      chk("arst_out_src",   a.out_src,   2'b00);
      chk("arst_in_ready",  a.in_ready,  3'b000);
      #1;
      rst_n      = 1'b1;
      a.in_valid = 3'b110;
      #1;
      chk("post_rst_ready", a.in_ready, 3'b010);
      chk("post_rst_sel",   a.sel,      2'b01);
      step();
      chk("post_rst_data", a.out_data, 8'hB1);
      chk("post_rst_src",  a.out_src,  2'd1);
      a.in_valid = 3'b000;

      // Burst of 3 on instance b
      b.in_valid = 3'b111;
      #1;
      chk("bu_first_ready", b.in_ready, 3'b001);
      for (int i = 0; i < 11; i++) begin
         step();
         chk("bu_src",   b.out_src,   32'(bu_src[i]));
         chk("bu_data",  b.out_data,  bu_d[bu_src[i]]);
         chk("bu_valid", b.out_valid, 1'b1);
      end

      // Source 0 drops after its 2nd burst transfer: grant moves to 1 with a fresh budget
      b.in_valid = 3'b110;
      #1;
      chk("bu_drop_ready", b.in_ready, 3'b010);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bu_drop_src",  b.out_src,  2'd1);
         chk("bu_drop_data", b.out_data, 8'h21);
      end
      step();
      chk("bu_after_src", b.out_src, 2'd2);
      b.in_valid = 3'b000;

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux3_1_rr_sched.md
Name: mux3_1_rr_sched

Overview:
Round-robin scheduler that shares one 3:1 datapath mux between three valid/ready requesters and drives a single registered output stage. It generates the mux select (sel, same encoding as the 3:1 mux: 00=d0, 01=d1, 10=d2). It captures the mux output into a one-entry output buffer. Optional burst locking lets a granted source keep the mux for several consecutive transfers.

Parameters:
WIDTH, 8, data width of each requester and of out_data
BURST, 1, max consecutive transfers granted to one source before rotation (1 = pure round-robin; legal 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  3  request/valid per source, bit i = source di
in_data0  input  WIDTH  source 0 payload
in_data1  input  WIDTH  source 1 payload
in_data2  input  WIDTH  source 2 payload
in_ready  output  3  one-hot (or zero) accept strobe per source, combinational
sel  output  2  mux select for the current grant; never 2'b11
out_valid  output  1  output buffer holds valid data
out_data  output  WIDTH  registered mux output
out_src  output  2  source index of out_data
out_ready  input  1  downstream accept

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=2'b00, sel=2'b00, last=2 (first priority goes to source 0), burst_cnt=0, state=EMPTY. in_ready=0 while in reset.
- load_en = !out_valid || out_ready.
- Winner selection, combinational. Sources are searched in order last+1, last+2, last (mod 3), and the first source with in_valid=1 wins. Burst exception: if burst_cnt < BURST-1 and in_valid[last]=1, last wins again.
- sel = winner when any in_valid=1. Otherwise sel holds its registered previous value.
- in_ready[winner] = load_en && |in_valid. All other bits are 0. At most one bit is ever set.
- Transfer (in_valid[i] && in_ready[i]) at a rising edge:
  - out_data <= mux output (in_data of the winner).
  - out_src <= winner; out_valid <= 1; last <= winner.
  - burst_cnt <= (winner==last) ? burst_cnt+1 : 0. It saturates at BURST-1 and resets to 0 when the grant moves.
- load_en with no in_valid: out_valid <= 0. out_data, out_src, last and burst_cnt hold.
- !load_en (out_valid=1, out_ready=0): all state holds and in_ready=0. out_data and out_src must stay stable while stalled.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a transfer.
  - FULL -> FULL on a simultaneous pop and transfer (back-to-back, 1 transfer/cycle).
  - FULL -> EMPTY on a pop with no request.
- Latency: input accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
- Fairness: with BURST=1 and all sources continuously valid, grants go 0,1,2,0,1,2… Any requester waits at most 2*BURST grants.
- A requester that deasserts in_valid before being granted is dropped from arbitration without side effects. Rotation skips it.
- Reset mid-transfer clears the output buffer immediately. In-flight data is lost, and the first post-reset grant goes to the lowest valid index starting at 0.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=3'b111 -> out_valid=0, in_ready=0, sel=00. Release rst_n -> first accept is source 0 (in_ready=001, sel=00).
- Full contention, BURST=1, out_ready=1: in_valid=111, data0=0xA0, data1=0xB1, data2=0xC2 held -> out_data sequence A0,B1,C2,A0,B1,C2…; out_src 0,1,2,…; one transfer every cycle.
- Sparse and skip: in_valid=101 after last=0 -> grant goes to 2 (sel=10). Then in_valid=001 -> grant 0. Source 1 is never granted and in_ready[1]=0 throughout.
- Backpressure: out_valid=1 with out_data=0x55, hold out_ready=0 for 4 cycles while in_valid=111 -> in_ready=000, out_data stays 0x55, last unchanged. Raise out_ready -> next grant continues rotation.
- Burst, BURST=3, all valid -> out_src sequence 0,0,0,1,1,1,2,2,2,0… Drop in_valid[0] after the 2nd transfer -> grant moves to 1 immediately with burst_cnt=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid falls without a clock edge, and out_data=0 and out_src=00 immediately.
